// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants for the instruction fetch unit
package fetch_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] INSTR_NOP = 32'h0000_0013;
  localparam int PC_STEP = 4;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO with push/pop/flush and occupancy count
module fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_pop = pop && count != '0;
  assign do_push = push && !flush && (count != CW'(DEPTH) || do_pop);
  assign head = mem[rp];
  assign empty = count == '0;
  // Pointer and occupancy tracking; flush wins over everything else
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n || flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  // Storage needs no reset: entries are only read once written
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= push_data;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with redirect squashing and an IF/ID queue
module fetch_unit import fetch_pkg::*; #(
  parameter int XLEN = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int FQ_DEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_redirect_valid,
  input  logic [XLEN-1:0]    i_redirect_pc,
  output logic               o_imem_req,
  output logic [XLEN-1:0]    o_imem_addr,
  input  logic               i_imem_ready,
  input  logic               i_imem_rvalid,
  input  logic [INSTR_W-1:0] i_imem_rdata,
  output logic               o_if_id_valid,
  output logic [XLEN-1:0]    o_if_id_pc,
  output logic [INSTR_W-1:0] o_if_id_instruction,
  input  logic               i_id_ready
);
  localparam int CW = $clog2(FQ_DEPTH) + 1;
  localparam int EW = XLEN + INSTR_W;
  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);
  localparam logic [CW:0] DEPTH_LIM = (CW+1)'(FQ_DEPTH);
  logic [XLEN-1:0] fetch_pc, resp_pc, redirect_pc;
  logic [CW-1:0] in_flight, discard_cnt, q_count, in_flight_nx;
  logic accept, resp_ok, keep, pop, q_empty;
  logic [EW-1:0] q_head;
  logic unused_low_bits;
  assign unused_low_bits = ^i_redirect_pc[1:0];
  assign redirect_pc = {i_redirect_pc[XLEN-1:2], 2'b00};
  assign o_imem_req = i_reset_n && !i_redirect_valid && ({1'b0, q_count} + {1'b0, in_flight}) < DEPTH_LIM;
  assign o_imem_addr = fetch_pc;
  assign accept = o_imem_req && i_imem_ready;
  assign resp_ok = i_imem_rvalid && in_flight != '0;
  assign keep = resp_ok && !i_redirect_valid && discard_cnt == '0;
  assign pop = o_if_id_valid && i_id_ready;
  assign in_flight_nx = in_flight + CW'(accept) - CW'(resp_ok);
  assign o_if_id_valid = !q_empty;
  assign o_if_id_pc = o_if_id_valid ? q_head[EW-1:INSTR_W] : '0;
  assign o_if_id_instruction = o_if_id_valid ? q_head[INSTR_W-1:0] : INSTR_NOP;
  // Fetch/response PCs plus outstanding and to-be-squashed response counts
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      fetch_pc <= RESET_PC;
      resp_pc <= RESET_PC;
      in_flight <= '0;
      discard_cnt <= '0;
    end else begin
      in_flight <= in_flight_nx;
      fetch_pc <= i_redirect_valid ? redirect_pc : accept ? fetch_pc + STEP : fetch_pc;
      resp_pc <= i_redirect_valid ? redirect_pc : keep ? resp_pc + STEP : resp_pc;
      discard_cnt <= i_redirect_valid ? in_flight_nx : discard_cnt - CW'(resp_ok && discard_cnt != '0);
    end
  fetch_queue #(.WIDTH(EW), .DEPTH(FQ_DEPTH)) u_queue (
    .clk(i_clk),
    .rst_n(i_reset_n),
    .push(keep),
    .push_data({resp_pc, i_imem_rdata}),
    .pop(pop),
    .flush(i_redirect_valid),
    .head(q_head),
    .empty(q_empty),
    .count(q_count)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenario bench for fetch_unit with an in-order memory model
module tb_fetch_unit;
  import fetch_pkg::*;
  logic i_clk = 0, i_reset_n = 0, i_redirect_valid = 0, i_imem_ready = 0, i_id_ready = 0;
  logic [31:0] i_redirect_pc = '0;
  logic i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic o_imem_req, o_if_id_valid;
  logic [31:0] o_imem_addr, o_if_id_pc, o_if_id_instruction;
  logic hold = 0;
  logic [31:0] mq [$];
  int checks = 0, errors = 0;
  always #5 i_clk = ~i_clk;
  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FQ_DEPTH(4)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_redirect_valid(i_redirect_valid), .i_redirect_pc(i_redirect_pc),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_ready(i_imem_ready),
    .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .o_if_id_valid(o_if_id_valid), .o_if_id_pc(o_if_id_pc),
    .o_if_id_instruction(o_if_id_instruction), .i_id_ready(i_id_ready)
  );
  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction
  // In-order memory: answers accepted requests one per cycle, at least a cycle later, unless held
  always @(posedge i_clk) begin
    if (!hold && mq.size() != 0) begin
      i_imem_rvalid <= 1'b1;
      i_imem_rdata <= word(mq.pop_front());
    end else begin
      i_imem_rvalid <= 1'b0;
      i_imem_rdata <= '0;
    end
    if (o_imem_req && i_imem_ready) mq.push_back(o_imem_addr);
  end
  task automatic do_reset(input logic h, input logic rdy, input logic idr);
    i_reset_n = 0;
    hold = 0;
    i_redirect_valid = 0;
    repeat (5) @(negedge i_clk);
    hold = h;
    i_imem_ready = rdy;
    i_id_ready = idr;
    i_reset_n = 1;
  endtask
  task automatic test_reset();
    repeat (3) @(negedge i_clk);
    checks++; if (o_imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b want=0", o_imem_req); end
    checks++; if (o_if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", o_if_id_valid); end
    checks++; if (o_if_id_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h want=0", o_if_id_pc); end
    checks++; if (o_if_id_instruction !== INSTR_NOP) begin errors++; $display("FAIL reset_instr got=%h want=%h", o_if_id_instruction, INSTR_NOP); end
    i_imem_ready = 1;
    i_id_ready = 1;
    i_reset_n = 1;
    #1;
    checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0) begin errors++; $display("FAIL first_req got req=%b addr=%h want req=1 addr=0", o_imem_req, o_imem_addr); end
  endtask
  task automatic test_stream();
    repeat (2) begin
      @(negedge i_clk);
      checks++; if (o_if_id_valid !== 1'b0) begin errors++; $display("FAIL early_valid got=%b want=0", o_if_id_valid); end
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge i_clk);
      checks++;
      if (o_if_id_valid !== 1'b1 || o_if_id_pc !== 32'(4 * i) || o_if_id_instruction !== word(32'(4 * i))) begin
        errors++; $display("FAIL stream got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", o_if_id_valid, o_if_id_pc, o_if_id_instruction, 32'(4 * i), word(32'(4 * i)));
      end
    end
  endtask
  task automatic test_stall();
    logic [31:0] exp = 0;
    int got = 0;
    do_reset(0, 1, 0);
    repeat (10) @(negedge i_clk);
    checks++; if (o_imem_req !== 1'b0) begin errors++; $display("FAIL stall_req got=%b want=0", o_imem_req); end
    checks++; if (o_if_id_valid !== 1'b1 || o_if_id_pc !== 32'h0 || o_if_id_instruction !== word(0)) begin errors++; $display("FAIL stall_head got v=%b pc=%h ins=%h want v=1 pc=0 ins=%h", o_if_id_valid, o_if_id_pc, o_if_id_instruction, word(0)); end
    i_id_ready = 1;
    for (int c = 0; c < 30 && got < 5; c++) begin
      if (o_if_id_valid) begin
        checks++; if (o_if_id_pc !== exp || o_if_id_instruction !== word(exp)) begin errors++; $display("FAIL stall_release got pc=%h ins=%h want pc=%h ins=%h", o_if_id_pc, o_if_id_instruction, exp, word(exp)); end
        exp += 4; got++;
      end
      @(negedge i_clk);
    end
    checks++; if (got !== 5) begin errors++; $display("FAIL stall_release_count got=%0d want=5", got); end
  endtask
  task automatic test_redirect();
    logic [31:0] exp;
    int got;
    logic [31:0] tgt [3] = '{32'h100, 32'h203, 32'hFFFF_FFF8};
    int n [3] = '{4, 3, 4};
    do_reset(1, 1, 1);
    repeat (3) @(negedge i_clk);
    checks++; if (o_imem_addr !== 32'hC) begin errors++; $display("FAIL three_inflight addr got=%h want=c", o_imem_addr); end
    for (int k = 0; k < 3; k++) begin
      i_redirect_valid = 1;
      i_redirect_pc = tgt[k];
      #1;
      checks++; if (o_imem_req !== 1'b0) begin errors++; $display("FAIL redirect_req got=%b want=0", o_imem_req); end
      @(negedge i_clk);
      i_redirect_valid = 0;
      hold = 0;
      #1;
      exp = {tgt[k][31:2], 2'b00};
      checks++; if (o_if_id_valid !== 1'b0) begin errors++; $display("FAIL redirect_valid got=%b want=0", o_if_id_valid); end
      checks++; if (o_imem_addr !== exp) begin errors++; $display("FAIL redirect_addr got=%h want=%h", o_imem_addr, exp); end
      got = 0;
      for (int c = 0; c < 40 && got < n[k]; c++) begin
        if (o_if_id_valid) begin
          checks++; if (o_if_id_pc !== exp || o_if_id_instruction !== word(exp)) begin errors++; $display("FAIL redirect_stream got pc=%h ins=%h want pc=%h ins=%h", o_if_id_pc, o_if_id_instruction, exp, word(exp)); end
          exp += 4; got++;
        end
        @(negedge i_clk);
      end
      checks++; if (got !== n[k]) begin errors++; $display("FAIL redirect_count got=%0d want=%0d", got, n[k]); end
    end
  endtask
  task automatic test_ready_toggle();
    logic [31:0] exp = 0, prev_addr = 0;
    logic stalled = 0;
    int got = 0;
    do_reset(0, 0, 1);
    for (int c = 0; c < 40; c++) begin
      if (stalled) begin
        checks++; if (o_imem_addr !== prev_addr) begin errors++; $display("FAIL addr_hold got=%h want=%h", o_imem_addr, prev_addr); end
      end
      if (o_if_id_valid) begin
        checks++; if (o_if_id_pc !== exp || o_if_id_instruction !== word(exp)) begin errors++; $display("FAIL toggle_stream got pc=%h ins=%h want pc=%h ins=%h", o_if_id_pc, o_if_id_instruction, exp, word(exp)); end
        exp += 4; got++;
      end
      i_imem_ready = ~i_imem_ready;
      stalled = o_imem_req && !i_imem_ready;
      prev_addr = o_imem_addr;
      @(negedge i_clk);
    end
    checks++; if (got < 10) begin errors++; $display("FAIL toggle_count got=%0d want>=10", got); end
  endtask
  task automatic test_reset_midflight();
    logic [31:0] exp = 0;
    int got = 0;
    do_reset(1, 1, 1);
    repeat (2) @(negedge i_clk);
    i_reset_n = 0;
    hold = 0;
    #1;
    checks++; if (o_imem_req !== 1'b0 || o_if_id_valid !== 1'b0) begin errors++; $display("FAIL midreset_outputs got req=%b v=%b want 0 0", o_imem_req, o_if_id_valid); end
    repeat (4) @(negedge i_clk);
    i_reset_n = 1;
    for (int c = 0; c < 20 && got < 3; c++) begin
      if (o_if_id_valid) begin
        checks++; if (o_if_id_pc !== exp || o_if_id_instruction !== word(exp)) begin errors++; $display("FAIL midreset_stream got pc=%h ins=%h want pc=%h ins=%h", o_if_id_pc, o_if_id_instruction, exp, word(exp)); end
        exp += 4; got++;
      end
      @(negedge i_clk);
    end
    checks++; if (got !== 3) begin errors++; $display("FAIL midreset_count got=%0d want=3", got); end
  endtask
  // Scenario sequence
  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_ready_toggle();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
